sccb_byte_master: RTL and testbench

//  Byte-level SCCB/I2C write master. It sits directly downstream of the SCCB register-sequencing control unit and upstream of the OV7670 pins.
//  - Consumes per-byte commands: en, start, stop, tx_data.
//  - Generates START, 8 data bits MSB-first, a 9th (ACK) bit and STOP on SCL/SDA.
//  - Returns tx_done / ack_error pulses so the sequencer can chain slave-addr, reg-addr and reg-data bytes.

---
 rtl/sccb_byte_master.sv | 177 +++++++++++++++++
 tb/tb_sccb_byte_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_byte_master.sv
// Byte-level SCCB/I2C write master: START, 8 data bits MSB-first, ACK slot, STOP.
// Optional feature macro: SCCB_ACK_CHECK_EN (sample 9th bit, pulse ack_error and abort on NACK).
module sccb_byte_master #(
    parameter int SYS_CLOCK_FREQ    = 100_000_000,
    parameter int TARGET_CLOCK_FREQ = 100_000,
    parameter int DIV_SCALE         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_ready,
    output logic       ack_error,
    output logic       SCL,
    inout  wire        SDA,
    output logic [2:0] dbg_state_o
);
    localparam int QTR = SYS_CLOCK_FREQ / (TARGET_CLOCK_FREQ * DIV_SCALE);
    localparam int CW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] QTR_LAST = CW'(QTR - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_ACK, ST_STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          pending_q, pending_d;
    logic          tx_done_q, tx_done_d;
    logic          ack_error_q, ack_error_d;
    logic          scl_q, scl_d;
    logic          sda_low_q, sda_low_d;
    logic          tick, bit_end, nack;

    assign tick    = (cnt_q == QTR_LAST);
    assign bit_end = tick && (phase_q == 2'd3);

`ifdef SCCB_ACK_CHECK_EN
    localparam logic [CW-1:0] QTR_MID = CW'(QTR / 2);
    logic nack_q, nack_d;

    // Slave response is sampled once, mid-way through the SCL-high part of the 9th bit.
    always_comb begin
        nack_d = nack_q;
        if (state_q == ST_ACK && phase_q == 2'd2 && cnt_q == QTR_MID) begin
            nack_d = SDA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) nack_q <= 1'b0;
        else       nack_q <= nack_d;
    end

    assign nack = nack_q;
`else
    assign nack = 1'b0;
`endif

    // Line levels {scl, sda_low} for a given state/phase; outputs are registered from next-state values.
    function automatic logic [1:0] line_levels(state_t st, logic [1:0] ph, logic bit_v);
        logic scl_hi;
        scl_hi = (ph == 2'd1) || (ph == 2'd2);
        case (st)
            ST_START: begin
                if (ph == 2'd3)      return 2'b01;
                else if (ph == 2'd2) return 2'b11;
                else                 return 2'b10;
            end
            ST_DATA: return {scl_hi, ~bit_v};
            ST_ACK:  return {scl_hi, 1'b0};
            ST_STOP: begin
                if (ph == 2'd0)      return 2'b01;
                else if (ph == 2'd1) return 2'b11;
                else                 return 2'b10;
            end
            default: return 2'b10;
        endcase
    endfunction

    always_comb begin
        cnt_d   = '0;
        phase_d = 2'd0;
        if (state_q != ST_IDLE) begin
            cnt_d   = tick ? '0 : cnt_q + CW'(1);
            phase_d = tick ? phase_q + 2'd1 : phase_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        pending_d   = pending_q;
        tx_done_d   = 1'b0;
        ack_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && (start || pending_q)) begin
                    shreg_d   = tx_data;
                    pending_d = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_d   = 3'd7;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                    if (bit_q == 3'd0) state_d = ST_ACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            ST_ACK: begin
                if (bit_end) begin
                    tx_done_d   = 1'b1;
                    ack_error_d = nack;
                    if (nack || stop || !en) begin
                        state_d = ST_STOP;
                    end else begin
                        shreg_d = tx_data;
                        bit_d   = 3'd7;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_STOP: begin
                // A start arriving during STOP is remembered and launched from IDLE.
                if (start)   pending_d = 1'b1;
                if (bit_end) state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        {scl_d, sda_low_d} = line_levels(state_d, phase_d, shreg_d[7]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_q     <= 2'd0;
            bit_q       <= 3'd7;
            shreg_q     <= 8'h00;
            pending_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            ack_error_q <= 1'b0;
            scl_q       <= 1'b1;
            sda_low_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            pending_q   <= pending_d;
            tx_done_q   <= tx_done_d;
            ack_error_q <= ack_error_d;
            scl_q       <= scl_d;
            sda_low_q   <= sda_low_d;
        end
    end

    assign SDA         = sda_low_q ? 1'b0 : 1'bz;
    assign SCL         = scl_q;
    assign tx_done     = tx_done_q;
    assign ack_error   = ack_error_q;
    assign tx_ready    = (state_q == ST_IDLE) && !pending_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sccb_byte_master.sv
// Bench for sccb_byte_master: decodes the SCL/SDA bus into bytes and checks them and the
// tx_done / tx_ready timing against cycle counts derived from the phase arithmetic.
module tb_sccb_byte_master;
    localparam int Q      = 5;          // clk per phase with the parameters below
    localparam int BYTE1  = 40 * Q;     // START + 8 data + ACK
    localparam int CHAIN  = 36 * Q;     // 8 data + ACK
    localparam int STOPC  = 4 * Q;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, start, stop;
    logic [7:0] tx_data;
    logic       tx_done, tx_ready, ack_error, scl;
    logic [2:0] dbg_state;
    wire        sda_w;
    logic       slave_low = 1'b0;
    logic       slave_ack = 1'b1;

    pullup (sda_w);
    assign sda_w = slave_low ? 1'b0 : 1'bz;

    sccb_byte_master #(
        .SYS_CLOCK_FREQ   (100_000_000),
        .TARGET_CLOCK_FREQ(5_000_000),
        .DIV_SCALE        (4)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .en         (en),
        .start      (start),
        .stop       (stop),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .tx_ready   (tx_ready),
        .ack_error  (ack_error),
        .SCL        (scl),
        .SDA        (sda_w),
        .dbg_state_o(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] chain_b[4];

    // bus monitor + ACKing slave
    int   n_start = 0, n_stop = 0, bit_n = 0;
    logic in_frame = 1'b0, p_scl = 1'b1, p_sda = 1'b1;
    logic [7:0] mon_sh = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            bit_n = 0; in_frame = 1'b0; slave_low = 1'b0;
        end else begin
            if (p_scl && scl && p_sda && !sda_w) begin
                n_start++; bit_n = 0; in_frame = 1'b1;
            end else if (p_scl && scl && !p_sda && sda_w) begin
                n_stop++; bit_n = 0; in_frame = 1'b0; slave_low = 1'b0;
            end else if (!p_scl && scl && in_frame) begin
                if (bit_n < 8) begin
                    mon_sh = {mon_sh[6:0], sda_w};
                    bit_n++;
                    if (bit_n == 8) got_q.push_back(mon_sh);
                end else begin
                    bit_n = 0;
                end
            end
            if (p_scl && !scl && in_frame) slave_low = slave_ack && (bit_n == 8);
        end
        p_scl = scl;
        p_sda = sda_w;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        check({tag, "_ready_wait"}, tx_ready, 1);
    endtask

    task automatic wait_done(output int td, output bit ready_seen);
        td = -1;
        ready_seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_ready) ready_seen = 1'b1;
            if (tx_done) begin
                td = cyc;
                break;
            end
        end
    endtask

    task automatic wait_ready_rise(input string tag, input int td);
        int tr;
        tr = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                tr = cyc;
                break;
            end
        end
        check({tag, "_ready_cyc"}, tr, td + STOPC);
    endtask

    task automatic drain(input string tag);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    // n-byte transaction; by_en ends it by dropping en instead of raising stop
    task automatic send_chain(input int n, input bit by_en, input string tag);
        int t0, td, s0, p0, j;
        bit rs;
        s0 = n_start;
        p0 = n_stop;
        wait_ready(tag);
        en = 1'b1; stop = !by_en && (n == 1); tx_data = chain_b[0]; start = 1'b1;
        @(negedge clk);
        t0 = cyc; start = 1'b0;
        exp_q.push_back(chain_b[0]);
        tx_data = chain_b[1];
        en = !(by_en && n == 1);
        start = 1'b1;                       // stray request while busy: must be ignored
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            wait_done(td, rs);
            check({tag, "_done_cyc"}, td, t0 + BYTE1 + CHAIN * k);
            check({tag, "_ack_err"}, ack_error, 0);
            check({tag, "_busy_ready"}, rs, 0);
            if (k < n - 1) begin
                j = k + 1;
                exp_q.push_back(chain_b[j]);
                tx_data = chain_b[(j + 1) % 4];
                stop = !by_en && (j == n - 1);
                en = !(by_en && j == n - 1);
            end
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, tx_done, 0);
        wait_ready_rise(tag, td);
        stop = 1'b0; en = 1'b1;
        check({tag, "_starts"}, n_start - s0, 1);
        check({tag, "_stops"}, n_stop - p0, 1);
        drain(tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, td, td2, s0, p0;
        bit rs, found;
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda_w, 1);
        check("rst_done", tx_done, 0);
        check("rst_ackerr", ack_error, 0);
        check("rst_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: single byte 0x42
        chain_b[0] = 8'h42; chain_b[1] = 8'h00;
        send_chain(1, 1'b0, "t1");

        // T2: three-byte chain
        chain_b[0] = 8'h42; chain_b[1] = 8'h12; chain_b[2] = 8'h80; chain_b[3] = 8'h00;
        send_chain(3, 1'b0, "t2");

        // en dropped mid-byte ends the transaction
        chain_b[0] = 8'hA5; chain_b[1] = 8'h3C; chain_b[2] = 8'hFF;
        send_chain(1, 1'b1, "en_drop1");
        send_chain(2, 1'b1, "en_drop2");

        // start with en=0 in IDLE is ignored
        s0 = n_start;
        en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * Q) @(negedge clk);
        check("en0_ready", tx_ready, 1);
        check("en0_scl", scl, 1);
        check("en0_starts", n_start - s0, 0);
        en = 1'b1;

`ifdef SCCB_ACK_CHECK_EN
        // T3: NACK on first byte aborts the chain
        slave_ack = 1'b0;
        chain_b[0] = 8'($urandom); chain_b[1] = 8'($urandom);
        s0 = n_start; p0 = n_stop;
        wait_ready("t3");
        en = 1'b1; stop = 1'b0; tx_data = chain_b[0]; start = 1'b1;
        @(negedge clk);
        t0 = cyc; start = 1'b0; tx_data = chain_b[1];
        exp_q.push_back(chain_b[0]);
        wait_done(td, rs);
        check("t3_done_cyc", td, t0 + BYTE1);
        check("t3_ack_err", ack_error, 1);
        found = 1'b0;
        for (int i = 0; i < BYTE1 + 8 * Q; i++) begin
            @(negedge clk);
            if (tx_done) found = 1'b1;
        end
        check("t3_no_byte2", found, 0);
        check("t3_starts", n_start - s0, 1);
        check("t3_stops", n_stop - p0, 1);
        drain("t3");
        slave_ack = 1'b1;
`else
        // T4: no slave ACK, ack_error stays low, all bytes go out
        slave_ack = 1'b0;
        for (int i = 0; i < 4; i++) chain_b[i] = 8'($urandom);
        send_chain(3, 1'b0, "t4");
        slave_ack = 1'b1;
`endif

        // T5: start during STOP is held pending and launched right after
        chain_b[0] = 8'($urandom); chain_b[1] = 8'($urandom);
        s0 = n_start; p0 = n_stop;
        wait_ready("t5");
        en = 1'b1; stop = 1'b1; tx_data = chain_b[0]; start = 1'b1;
        @(negedge clk);
        t0 = cyc; start = 1'b0;
        exp_q.push_back(chain_b[0]);
        wait_done(td, rs);
        check("t5_done1_cyc", td, t0 + BYTE1);
        @(negedge clk);
        start = 1'b1; tx_data = chain_b[1];
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back(chain_b[1]);
        wait_done(td2, rs);
        check("t5_done2_cyc", td2, td + STOPC + 1 + BYTE1);
        check("t5_ready_low", rs, 0);
        wait_ready_rise("t5", td2);
        check("t5_starts", n_start - s0, 2);
        check("t5_stops", n_stop - p0, 2);
        drain("t5");

        // T6: reset during data bit 4, then a clean byte
        chain_b[0] = 8'($urandom);
        wait_ready("t6");
        en = 1'b1; stop = 1'b1; tx_data = chain_b[0]; start = 1'b1;
        @(negedge clk);
        t0 = cyc; start = 1'b0;
        for (int i = 0; i < 40 * Q && cyc < t0 + 16 * Q + 1; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_scl", scl, 1);
        check("t6_sda", sda_w, 1);
        check("t6_done", tx_done, 0);
        check("t6_ready", tx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        @(negedge clk);
        chain_b[0] = 8'($urandom);
        send_chain(1, 1'b0, "t6_after");

        // randomized chains
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) chain_b[i] = 8'($urandom);
            send_chain(n, 1'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
